// File: rtl/hx711_reader.sv
// hx711_reader: bit-bang HX711 reader, 24 data bits MSB first plus 1-3 gain pulses.
// Optional HX711_TIMEOUT_EN bounds the wait for DOUT low to TIMEOUT_CYCLES clks.
module hx711_reader #(
  parameter int HALF_CYCLES    = 64,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  gain_sel,
  input  logic        dout,
  output logic        pd_sck,
  output logic [23:0] data,
  output logic        valid,
  output logic        busy,
  output logic        timeout
);
  typedef enum logic [2:0] {IDLE, WAIT_READY, SCK_HIGH, SCK_LOW, DONE} state_t;
  state_t      state_q, state_d;
  logic        dout_m_q, dout_s_q;
  logic [9:0]  hc_q, hc_d;
  logic [4:0]  bit_q, bit_d, pulses_q, pulses_d;
  logic [23:0] shift_q, shift_d, data_q, data_d;
  logic        pd_sck_q, valid_q, busy_q;
  logic        half_done;
  if (HALF_CYCLES < 4 || HALF_CYCLES > 1023 || TIMEOUT_CYCLES < 1)
    $error("hx711_reader: HALF_CYCLES must be 4..1023 and TIMEOUT_CYCLES >= 1");
`ifdef HX711_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q, to_d;
  logic          timeout_q, timeout_d;
`endif
  always_comb begin
    state_d   = state_q;
    hc_d      = hc_q;
    bit_d     = bit_q;
    pulses_d  = pulses_q;
    shift_d   = shift_q;
    half_done = hc_q == 10'(HALF_CYCLES - 1);
`ifdef HX711_TIMEOUT_EN
    to_d      = to_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (start) begin
        pulses_d = 5'd24 + (gain_sel == 2'd0 ? 5'd1 : {3'b000, gain_sel});
        bit_d    = '0;
        hc_d     = '0;
        state_d  = WAIT_READY;
`ifdef HX711_TIMEOUT_EN
        to_d     = '0;
`endif
      end
      WAIT_READY: begin
        if (!dout_s_q) state_d = SCK_HIGH;
`ifdef HX711_TIMEOUT_EN
        else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else to_d = to_q + TW'(1);
`endif
      end
      SCK_HIGH: begin
        hc_d = half_done ? '0 : hc_q + 10'd1;
        if (half_done) begin
          shift_d = bit_q < 5'd24 ? {shift_q[22:0], dout_s_q} : shift_q;
          state_d = SCK_LOW;
        end
      end
      SCK_LOW: begin
        hc_d = half_done ? '0 : hc_q + 10'd1;
        if (half_done) begin
          bit_d   = bit_q + 5'd1;
          state_d = bit_d == pulses_q ? DONE : SCK_HIGH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    data_d = state_d == DONE ? shift_d : data_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dout_m_q <= 1'b1;
      dout_s_q <= 1'b1;
      hc_q     <= '0;
      bit_q    <= '0;
      pulses_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      pd_sck_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dout_m_q <= dout;
      dout_s_q <= dout_m_q;
      hc_q     <= hc_d;
      bit_q    <= bit_d;
      pulses_q <= pulses_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      pd_sck_q <= state_d == SCK_HIGH;
      valid_q  <= state_d == DONE;
      busy_q   <= state_d != IDLE;
    end
  end
`ifdef HX711_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_q      <= to_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif
  assign pd_sck = pd_sck_q;
  assign data   = data_q;
  assign valid  = valid_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_hx711_reader.sv
// tb_hx711_reader: directed bench with a behavioural HX711 driving DOUT from pulse count.
module tb_hx711_reader;
  localparam int HALF = 64;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0] gain_sel = 2'd1;
  logic dout, pd_sck, valid, busy, timeout;
  logic [23:0] data;
  logic ready_n = 1'b1;
  logic [23:0] pat = '0;
  int base = 0;
  int sck_cnt = 0, vcnt = 0, tocnt = 0, bad_hi = 0, bad_lo = 0, hi_run = 0, lo_run = 0;
  bit lo_ok = 0, prev = 0;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  hx711_reader #(.HALF_CYCLES(HALF), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gain_sel(gain_sel), .dout(dout),
    .pd_sck(pd_sck), .data(data), .valid(valid), .busy(busy), .timeout(timeout)
  );

  // HX711: DOUT low when ready, next data bit after each rising PD_SCK, high after bit 24
  function automatic logic model_bit(input int rel, input logic [23:0] p);
    return (rel == 0) ? 1'b0 : (rel > 24) ? 1'b1 : p[24-rel];
  endfunction
  assign dout = ready_n | model_bit(sck_cnt - base, pat);

  always @(negedge clk) begin
    if (!rst_n) begin
      hi_run = 0; lo_run = 0; lo_ok = 0; prev = 0;
    end else begin
      if (pd_sck) begin
        if (!prev) begin
          sck_cnt++;
          if (lo_ok && lo_run != HALF) bad_lo++;
        end
        hi_run++; lo_run = 0;
      end else begin
        if (prev) begin
          if (hi_run != HALF) bad_hi++;
          lo_ok = 1;
        end
        hi_run = 0; lo_run++;
      end
      if (valid) begin vcnt++; lo_ok = 0; end
      if (timeout) tocnt++;
      prev = pd_sck;
    end
  end

  task automatic wait_valid(output int cyc, output bit ok);
    cyc = 0;
    while (!valid && cyc < 10000) begin @(negedge clk); cyc++; end
    ok = valid;
  endtask

  task automatic do_read(input logic [1:0] g, input logic [23:0] p, output int lat, output bit ok);
    ready_n = 1'b1; pat = p; gain_sel = g; base = sck_cnt;
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    ready_n = 1'b0;
    wait_valid(lat, ok);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({pd_sck, valid, busy, timeout} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl got %b want 0000", {pd_sck, valid, busy, timeout}); end
    n_checks++; if (data !== 24'h0) begin n_fail++; $display("FAIL reset_data got %h want 000000", data); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_gain1();
    int lat, v0; bit ok;
    v0 = vcnt;
    do_read(2'd1, 24'h800001, lat, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL g1_valid_timeout got no valid want valid"); end
    n_checks++; if (lat !== 3 + 2*HALF*25) begin n_fail++; $display("FAIL g1_latency got %0d want %0d", lat, 3 + 2*HALF*25); end
    n_checks++; if (sck_cnt - base !== 25) begin n_fail++; $display("FAIL g1_pulses got %0d want 25", sck_cnt - base); end
    n_checks++; if (data !== 24'h800001) begin n_fail++; $display("FAIL g1_data got %h want 800001", data); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL g1_busy_at_valid got %b want 1", busy); end
    @(negedge clk);
    n_checks++; if ({busy, valid} !== 2'b00) begin n_fail++; $display("FAIL g1_after_valid busy/valid got %b want 00", {busy, valid}); end
    repeat (5) @(negedge clk);
    n_checks++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL g1_valid_count got %0d want 1", vcnt - v0); end
    n_checks++; if ({bad_hi, bad_lo} !== 64'd0) begin n_fail++; $display("FAIL g1_widths bad_hi %0d bad_lo %0d want 0 0", bad_hi, bad_lo); end
  endtask

  task automatic test_gains();
    logic [1:0] g [3] = '{2'd2, 2'd3, 2'd0};
    int exp_p [3] = '{26, 27, 25};
    int lat; bit ok;
    for (int i = 0; i < 3; i++) begin
      do_read(g[i], 24'h7FFFFF, lat, ok);
      n_checks++; if (!ok || sck_cnt - base !== exp_p[i]) begin n_fail++; $display("FAIL gain%0d_pulses got %0d (ok=%0b) want %0d", g[i], sck_cnt - base, ok, exp_p[i]); end
      n_checks++; if (data !== 24'h7FFFFF) begin n_fail++; $display("FAIL gain%0d_data got %h want 7fffff", g[i], data); end
      repeat (3) @(negedge clk);
    end
    n_checks++; if ({bad_hi, bad_lo} !== 64'd0) begin n_fail++; $display("FAIL gains_widths bad_hi %0d bad_lo %0d want 0 0", bad_hi, bad_lo); end
  endtask

  task automatic test_start_while_busy();
    int lat, v0; bit ok;
    v0 = vcnt; ready_n = 1'b1; pat = 24'hA5A5A5; gain_sel = 2'd1; base = sck_cnt;
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    ready_n = 1'b0;
    repeat (500) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_valid(lat, ok);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (400) @(negedge clk);
    n_checks++; if (!ok || data !== 24'hA5A5A5) begin n_fail++; $display("FAIL busy_start_data got %h (ok=%0b) want a5a5a5", data, ok); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle got %b want 0", busy); end
    n_checks++; if (sck_cnt - base !== 25) begin n_fail++; $display("FAIL busy_start_pulses got %0d want 25", sck_cnt - base); end
    n_checks++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL busy_start_valids got %0d want 1", vcnt - v0); end
  endtask

  task automatic test_back_to_back();
    int lat; bit ok;
    pat = 24'hC00003; gain_sel = 2'd1; base = sck_cnt; ready_n = 1'b0;
    start = 1'b1;
    wait_valid(lat, ok);
    n_checks++; if (!ok || data !== 24'hC00003) begin n_fail++; $display("FAIL b2b_first_data got %h (ok=%0b) want c00003", data, ok); end
    pat = 24'h123456; base = sck_cnt;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_cycle busy got %b want 0", busy); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart busy got %b want 1", busy); end
    wait_valid(lat, ok);
    start = 1'b0;
    n_checks++; if (!ok || data !== 24'h123456) begin n_fail++; $display("FAIL b2b_second_data got %h (ok=%0b) want 123456", data, ok); end
    n_checks++; if (sck_cnt - base !== 25) begin n_fail++; $display("FAIL b2b_second_pulses got %0d want 25", sck_cnt - base); end
    repeat (5) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stop busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_read();
    int lat, v0, cyc; bit ok;
    v0 = vcnt; ready_n = 1'b1; pat = 24'h5A5A5A; gain_sel = 2'd1; base = sck_cnt;
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    ready_n = 1'b0;
    cyc = 0;
    while (!(sck_cnt - base == 12 && pd_sck) && cyc < 5000) begin @(negedge clk); cyc++; end
    n_checks++; if (cyc >= 5000) begin n_fail++; $display("FAIL rst_mid_reach12 got timeout want 12th high phase"); end
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if ({pd_sck, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_ctrl pd_sck/busy got %b want 00", {pd_sck, busy}); end
    n_checks++; if (data !== 24'h0) begin n_fail++; $display("FAIL rst_mid_data got %h want 000000", data); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    n_checks++; if (vcnt !== v0) begin n_fail++; $display("FAIL rst_mid_no_valid got %0d want %0d", vcnt, v0); end
    do_read(2'd1, 24'h5A5A5A, lat, ok);
    n_checks++; if (!ok || data !== 24'h5A5A5A || sck_cnt - base !== 25) begin n_fail++; $display("FAIL rst_mid_fresh data %h pulses %0d ok %0b want 5a5a5a 25 1", data, sck_cnt - base, ok); end
    repeat (3) @(negedge clk);
  endtask

`ifdef HX711_TIMEOUT_EN
  task automatic test_timeout();
    int n, v0; logic [23:0] d0;
    v0 = vcnt; d0 = data; ready_n = 1'b1; base = sck_cnt;
    start = 1'b1; @(negedge clk); start = 1'b0;
    n = 1;
    while (!timeout && n < 500) begin @(negedge clk); n++; end
    n_checks++; if (n !== 101) begin n_fail++; $display("FAIL to_cycle got %0d want 101", n); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_busy got %b want 0", busy); end
    n_checks++; if (data !== d0 || sck_cnt - base !== 0) begin n_fail++; $display("FAIL to_held data %h pulses %0d want %h 0", data, sck_cnt - base, d0); end
    @(negedge clk);
    n_checks++; if (timeout !== 1'b0 || vcnt !== v0) begin n_fail++; $display("FAIL to_pulse timeout %b valids %0d want 0 %0d", timeout, vcnt - v0, 0); end
  endtask

  task automatic test_timeout_race();
    int lat, t0; bit ok;
    t0 = tocnt; ready_n = 1'b1; pat = 24'h0F0F0F; gain_sel = 2'd1; base = sck_cnt;
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (97) @(negedge clk);
    ready_n = 1'b0;
    wait_valid(lat, ok);
    n_checks++; if (tocnt !== t0) begin n_fail++; $display("FAIL race_timeout got %0d pulses want 0", tocnt - t0); end
    n_checks++; if (!ok || data !== 24'h0F0F0F || sck_cnt - base !== 25) begin n_fail++; $display("FAIL race_read data %h pulses %0d ok %0b want 0f0f0f 25 1", data, sck_cnt - base, ok); end
  endtask
`else
  task automatic test_no_timeout();
    int lat; bit ok;
    ready_n = 1'b1; pat = 24'h00FF00; gain_sel = 2'd1; base = sck_cnt;
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (300) @(negedge clk);
    n_checks++; if (busy !== 1'b1 || tocnt !== 0) begin n_fail++; $display("FAIL nto_wait busy %b timeouts %0d want 1 0", busy, tocnt); end
    ready_n = 1'b0;
    wait_valid(lat, ok);
    n_checks++; if (!ok || data !== 24'h00FF00) begin n_fail++; $display("FAIL nto_read data %h ok %0b want 00ff00 1", data, ok); end
  endtask
`endif

  initial begin
    test_reset();
    test_gain1();
    test_gains();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_read();
`ifdef HX711_TIMEOUT_EN
    test_timeout();
    test_timeout_race();
`else
    test_no_timeout();
`endif
    n_checks++; if ({bad_hi, bad_lo} !== 64'd0) begin n_fail++; $display("FAIL final_widths bad_hi %0d bad_lo %0d want 0 0", bad_hi, bad_lo); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hx711_reader.md
Name: hx711_reader

Overview:
- Bit-bang serial reader for the HX711 load-cell ADC, consuming the ~1.28 us (64-cycle) timing granularity used by the load-cell path.
- Waits for the ADC's data-ready (DOUT low), clocks out 24 data bits MSB first on PD_SCK, then issues 1–3 extra pulses to select the next channel/gain.
- Presents the raw 24-bit two's-complement sample to the Nios-facing register logic with a one-cycle valid strobe.

Parameters:
- HALF_CYCLES, 64, clk cycles per PD_SCK half-period (high and low phases each); legal range 4..1023.
- TIMEOUT_CYCLES, 5000000, clk cycles allowed in WAIT_READY before timeout (100 ms at 50 MHz); used only with HX711_TIMEOUT_EN.

Ports:
- clk  input  1  50 MHz system clock
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk
- start  input  1  request one conversion read; accepted only in IDLE
- gain_sel  input  2  next conversion: 1 = ch A gain 128, 2 = ch B gain 32, 3 = ch A gain 64, 0 treated as 1; latched when start is accepted
- dout  input  1  HX711 DOUT (asynchronous)
- pd_sck  output  1  HX711 PD_SCK, registered
- data  output  24  last captured sample, raw two's complement
- valid  output  1  one-cycle pulse when data updates
- busy  output  1  high in every state except IDLE
- timeout  output  1  one-cycle pulse on ready timeout (tied 0 without HX711_TIMEOUT_EN)

Behaviour:
- Reset (rst_n = 0 at posedge): state = IDLE, pd_sck = 0, data = 0, valid = 0, busy = 0, timeout = 0, shift register and counters = 0. Reset mid-read drops pd_sck low on that same edge and discards the partial sample.
- dout passes through a 2-flop synchronizer; all decisions use dout_s.
- IDLE: pd_sck = 0. When start = 1: latch pulses = 24 + (gain_sel == 0 ? 1 : gain_sel), clear the bit counter, go to WAIT_READY.
- WAIT_READY: pd_sck = 0. When dout_s = 0: go to SCK_HIGH.
- SCK_HIGH: pd_sck = 1 for exactly HALF_CYCLES clks.
  - On the last cycle, if bit counter < 24, shift dout_s into the LSB of the shift register.
  - Then go to SCK_LOW.
- SCK_LOW: pd_sck = 0 for exactly HALF_CYCLES clks. On the last cycle, increment the bit counter.
  - If counter == pulses, go to DONE.
  - Otherwise go to SCK_HIGH.
- DONE (one cycle): data <= shift register, valid = 1, go to IDLE. start is ignored in DONE.
- Back-to-back reads with start held high: IDLE accepts on the cycle after DONE.
- start while busy is ignored; no queuing.
- pd_sck high time never exceeds HALF_CYCLES clks, which keeps the HX711 out of power-down (>60 us).
- Latency: WAIT_READY exit to valid = 2·HALF_CYCLES·pulses + 1 clks (3201 for gain 1, HALF_CYCLES = 64).
- Bit and half-period counters saturate or compare exactly; no wrap past the pulse count.

Optional Feature:
- Macro: HX711_TIMEOUT_EN.
- Defined: WAIT_READY counts clks. On reaching TIMEOUT_CYCLES with dout_s still 1: pulse timeout for one cycle, return to IDLE, leave data unchanged, no valid. The counter clears on entry to WAIT_READY. dout_s = 0 on the same cycle as terminal count takes precedence (read proceeds, no timeout).
- Undefined: WAIT_READY waits indefinitely; timeout tied 0; no timeout counter present.

Test Plan:
1. Reset, then start = 1 with gain_sel = 1; HX711 model drives 0x80_0001 with dout low after 10 clks -> exactly 25 pd_sck pulses, each 64 clks high and 64 low; data = 0x800001; valid pulses once; busy falls on the cycle after valid.
2. gain_sel = 2, then 3, then 0 with pattern 0x7FFFFF -> 26, 27 and 25 pulses respectively; data = 0x7FFFFF each time.
3. Assert start while busy mid-read, plus start in the DONE cycle -> no extra read, pulse count unchanged; start held high continuously -> back-to-back reads, IDLE lasts one cycle.
4. Drive rst_n = 0 during the 12th SCK_HIGH -> pd_sck = 0 on the next edge, data stays 0x000000, valid never fires; a fresh start afterwards completes normally.
5. HX711_TIMEOUT_EN with TIMEOUT_CYCLES = 100 and dout held high -> timeout pulses at the 100th WAIT_READY clk; no pd_sck pulses; data is held; busy drops.
6. HX711_TIMEOUT_EN with dout falling on the terminal-count cycle -> no timeout; read completes with valid.
